// File: rtl/instruction_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_responder
// Purpose  : Memory-side responder for instruction-cache refills. Accepts a
//            block-read request, waits a fixed latency, then streams one
//            aligned block of 32-bit words from an internal instruction store.
//            A backdoor write port loads the program image while idle.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int BLOCK_SIZE   = 4,
  parameter int READ_LATENCY = 3,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int IW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   mem_addr,
  input  logic          mem_read_req,
  output logic [31:0]   mem_data,
  output logic          mem_data_valid,
  output logic [IW-1:0] mem_word_idx,
  output logic          mem_ready,
  output logic          mem_error,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_wdata,
  output logic          prog_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Byte-address limit of the store; comparing the full byte address keeps
  // every request bit meaningful.
  localparam logic [32:0]   C_BYTE_LIMIT = 33'(MEM_WORDS) * 33'd4;
  localparam logic [AW-1:0] C_BLK_MASK   = AW'(BLOCK_SIZE - 1);
  localparam logic [3:0]    C_LAT_INIT   = 4'(READ_LATENCY - 1);
  localparam logic [IW-1:0] C_LAST_BEAT  = IW'(BLOCK_SIZE - 1);

  state_t        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic [IW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          oor_q, oor_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  logic [31:0]   store_q [MEM_WORDS];

  logic          w_oor;
  logic          w_emit;
  logic          w_last;
  logic [AW-1:0] w_rd_addr;

  assign w_oor     = ({1'b0, mem_addr} >= C_BYTE_LIMIT);
  // The base is block-aligned, so OR-ing in the beat equals base+beat and
  // can never carry into the next block.
  assign w_rd_addr = base_q | AW'(beat_q);
  // A word is produced on the last WAIT edge (beat 0) and on every BURST edge,
  // so each word appears registered exactly READ_LATENCY+k edges after accept.
  assign w_emit    = ((state_q == S_WAIT) && (lat_q == 4'd0)) || (state_q == S_BURST);
  assign w_last    = (beat_q == C_LAST_BEAT);

  // Program image store: written only through the backdoor while idle, never reset
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      store_q[prog_addr] <= prog_wdata;
    end
  end

  // Next-state and next-output logic for the request FSM
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    base_d  = base_q;
    oor_d   = oor_q;
    data_d  = data_q;
    valid_d = 1'b0;
    idx_d   = idx_q;
    ready_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_read_req) begin
          base_d  = mem_addr[AW+1:2] & ~C_BLK_MASK;
          oor_d   = w_oor;
          lat_d   = C_LAT_INIT;
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q != 4'd0) begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_BURST: begin
      end
      S_DONE: begin
        if (!mem_read_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_emit) begin
      valid_d = 1'b1;
      idx_d   = beat_q;
      data_d  = oor_q ? 32'd0 : store_q[w_rd_addr];
      if (w_last) begin
        ready_d = 1'b1;
        error_d = oor_q;
        state_d = S_DONE;
      end else begin
        beat_d  = beat_q + IW'(1);
        state_d = S_BURST;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_data       = data_q;
  assign mem_data_valid = valid_q;
  assign mem_word_idx   = idx_q;
  assign mem_ready      = ready_q;
  assign mem_error      = error_q;
  assign prog_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_responder
// Purpose  : Directed scoreboard bench for instruction_memory_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_responder;

  localparam int MEM_WORDS    = 4096;
  localparam int BLOCK_SIZE   = 4;
  localparam int READ_LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic        mem_read_req;
  logic [31:0] mem_data;
  logic        mem_data_valid;
  logic [1:0]  mem_word_idx;
  logic        mem_ready;
  logic        mem_error;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        prog_busy;

  instruction_memory_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_read_req  (mem_read_req),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .mem_word_idx  (mem_word_idx),
    .mem_ready     (mem_ready),
    .mem_error     (mem_error),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_wdata    (prog_wdata),
    .prog_busy     (prog_busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        rdy;
    logic        err;
    logic [31:0] at;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model [MEM_WORDS];
  int          nvec  = 0;
  int          nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected words of one burst accepted at edge e0
  task automatic push_burst(input int unsigned base, input bit oor,
                            input int unsigned e0, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = oor ? 32'd0 : model[base + k];
      b.idx  = 2'(k);
      b.rdy  = (k == BLOCK_SIZE - 1);
      b.err  = oor && (k == BLOCK_SIZE - 1);
      b.at   = e0 + READ_LATENCY + k;
      sb.push_back(b);
    end
  endtask

  task automatic prog(input logic [11:0] a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    model[a]   = d;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  // Raise the request at a falling edge; the next rising edge accepts it
  task automatic issue(input logic [31:0] a, output int unsigned e0);
    mem_addr     = a;
    mem_read_req = 1'b1;
    e0           = cyc + 1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (mem_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, 64'(mem_ready), 64'd1);
  endtask

  // Output monitor: every valid word is popped from the scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (mem_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(mem_data_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("beat_data",  64'(mem_data),     64'(e.data));
        check("beat_idx",   64'(mem_word_idx), 64'(e.idx));
        check("beat_ready", 64'(mem_ready),    64'(e.rdy));
        check("beat_error", 64'(mem_error),    64'(e.err));
        check("beat_cycle", 64'(cyc),          64'(e.at));
      end
    end else if (mem_ready !== 1'b0 || mem_error !== 1'b0) begin
      check("ready_without_valid", 64'({mem_ready, mem_error}), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    int          n;
    reset_n      = 1'b0;
    mem_read_req = 1'b0;
    mem_addr     = 32'd0;
    prog_we      = 1'b0;
    prog_addr    = 12'd0;
    prog_wdata   = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_mem_data",  64'(mem_data),       64'd0);
    check("rst_valid",     64'(mem_data_valid), 64'd0);
    check("rst_idx",       64'(mem_word_idx),   64'd0);
    check("rst_ready",     64'(mem_ready),      64'd0);
    check("rst_error",     64'(mem_error),      64'd0);
    check("rst_prog_busy", 64'(prog_busy),      64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Program image
    for (int k = 0; k < 4; k++) begin
      prog(12'h040 + 12'(k), 32'hA0 + 32'(k));
      prog(12'(k),           32'hB0 + 32'(k));
    end

    // Basic burst from 0x104 (block base word 0x40)
    issue(32'h0000_0104, e0);
    push_burst(32'h40, 1'b0, e0, 4);
    @(negedge clk);
    check("busy_in_wait", 64'(prog_busy), 64'd1);
    wait_ready("b1");
    check("busy_at_ready", 64'(prog_busy), 64'd1);
    mem_read_req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 64'(prog_busy), 64'd0);

    // Reissue immediately at address 0, then hold the request after ready
    issue(32'h0000_0000, e0);
    push_burst(32'h0, 1'b0, e0, 4);
    wait_ready("b2");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("held_no_burst", 64'(mem_data_valid), 64'd0);
      check("held_busy",     64'(prog_busy),      64'd1);
    end
    mem_read_req = 1'b0;
    @(negedge clk);
    check("held_release_idle", 64'(prog_busy), 64'd0);

    // Out-of-range block
    issue(32'h0001_0000, e0);
    push_burst(32'h0, 1'b1, e0, 4);
    wait_ready("oor");
    mem_read_req = 1'b0;
    @(negedge clk);

    // Backdoor write during WAIT is dropped
    issue(32'h0000_0100, e0);
    push_burst(32'h40, 1'b0, e0, 4);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = 12'h040;
    prog_wdata = 32'h1234_5678;
    @(negedge clk);
    prog_we    = 1'b0;
    wait_ready("wr_wait");
    mem_read_req = 1'b0;
    @(negedge clk);

    // Backdoor write in IDLE together with a request is seen on beat 0
    prog_we      = 1'b1;
    prog_addr    = 12'h040;
    prog_wdata   = 32'h1234_5678;
    model[12'h040] = 32'h1234_5678;
    issue(32'h0000_0100, e0);
    push_burst(32'h40, 1'b0, e0, 4);
    @(negedge clk);
    prog_we = 1'b0;
    wait_ready("wr_idle");
    mem_read_req = 1'b0;
    @(negedge clk);

    // Reset asserted during beat 2; the held request restarts a full burst
    issue(32'h0000_0104, e0);
    push_burst(32'h40, 1'b0, e0, 3);
    n = 0;
    while (!(mem_data_valid === 1'b1 && mem_word_idx == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat2_seen", 64'(mem_word_idx), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(mem_data_valid), 64'd0);
    check("arst_ready", 64'(mem_ready),      64'd0);
    check("arst_busy",  64'(prog_busy),      64'd0);
    check("arst_data",  64'(mem_data),       64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    e0 = cyc + 1;
    push_burst(32'h40, 1'b0, e0, 4);
    wait_ready("after_rst");
    mem_read_req = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_memory_responder.md
# instruction_memory_responder

Memory-side responder for the instruction-cache refill interface. It accepts a block-read request, waits a fixed access latency, and streams one aligned block of 32-bit words out of an internal word-addressed instruction store, one word per cycle. It sits between the instruction cache's memory-controller port and the program image. A backdoor write port loads the image.

## Interface
- MEM_WORDS, 4096, instruction store depth in 32-bit words; power of two.
- BLOCK_SIZE, 4, words per refill burst; power of two; must match the cache.
- READ_LATENCY, 3, cycles from request acceptance to first data word; legal range 1..15.
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_addr  input  32  byte address of the requested block; the low log2(BLOCK_SIZE)+2 bits are ignored.
- mem_read_req  input  1  level request from the cache; held until mem_ready is seen.
- mem_data  output  32  burst data word.
- mem_data_valid  output  1  mem_data carries a valid word this cycle.
- mem_word_idx  output  log2(BLOCK_SIZE)  index of the word within the block.
- mem_ready  output  1  single-cycle pulse coincident with the last word of the burst.
- mem_error  output  1  request was out of range; asserted together with mem_ready.
- prog_we  input  1  backdoor write enable.
- prog_addr  input  log2(MEM_WORDS)  backdoor word address.
- prog_wdata  input  32  backdoor write data.
- prog_busy  output  1  high whenever the FSM is not IDLE; backdoor writes are ignored while high.

## Operation
- FSM states:
  - IDLE: if mem_read_req=1, latch the aligned word base (mem_addr[31:2] with the low log2(BLOCK_SIZE) bits cleared). Load the latency counter with READ_LATENCY-1 and go to WAIT.
  - WAIT: the counter decrements each cycle. When it reaches 0, go to BURST with the beat counter at 0.
  - BURST: one word per cycle. mem_data = store[base+beat], mem_data_valid=1, mem_word_idx=beat. On beat BLOCK_SIZE-1, also assert mem_ready and go to DONE.
  - DONE: all outputs quiet. Stay until mem_read_req=0, then go to IDLE. This stops a held request from re-triggering.
- Range check at acceptance: if mem_addr[31:2] >= MEM_WORDS, the block is out of range.
  - Still run WAIT and BURST with the same timing.
  - mem_data is forced to 0 on every beat.
  - mem_error is asserted with mem_ready.
  - No wrap-around into the store.
- Beat arithmetic: base+beat never crosses a block boundary, because the base is aligned.
- A change to mem_addr after acceptance has no effect.
- Backdoor writes:
  - prog_we=1 in IDLE writes prog_wdata to store[prog_addr] at the clock edge.
  - If a request is accepted in the same cycle, the write still completes. Data for that burst is read from WAIT onward, so it sees the new value.
  - prog_we outside IDLE is dropped.
- The store is not cleared by reset.

## Timing
- Every output is registered.
- Reset values: mem_data=0, mem_data_valid=0, mem_word_idx=0, mem_ready=0, mem_error=0, prog_busy=0. FSM=IDLE, counters=0.
- Let E0 be the edge that samples mem_read_req=1 in IDLE:
  - Word k is valid in the cycle after edge E0+READ_LATENCY+k.
  - mem_ready is valid in the cycle after edge E0+READ_LATENCY+BLOCK_SIZE-1.
- prog_busy rises after E0 and falls after the edge at which DONE sees mem_read_req=0.
- Minimum request-to-request spacing: READ_LATENCY+BLOCK_SIZE+1 cycles. The cache drops its request on the mem_ready edge, so DONE lasts one cycle.
- Reset asserted mid-burst: outputs clear immediately and asynchronously, and the FSM goes to IDLE. After release, a still-high mem_read_req is accepted as a new request.
- mem_data holds its last value when mem_data_valid=0, except after reset (0).

## Test plan
- Preload store[0x40..0x43]=0xA0..0xA3. With mem_addr=0x104 and READ_LATENCY=3, hold the request. Required: words 0xA0,0xA1,0xA2,0xA3 with idx 0..3, first word in the cycle after E0+3, mem_ready with 0xA3, mem_error=0.
- Drop the request on mem_ready, then reissue after 1 cycle with mem_addr=0x0. Required: DONE lasts exactly 1 cycle and the second burst starts READ_LATENCY cycles after its acceptance.
- Keep mem_read_req high after mem_ready for 5 cycles. Required: no second burst; the FSM stays in DONE and prog_busy stays 1.
- Request mem_addr=0x0001_0000 with MEM_WORDS=4096. Required: 4 beats of data 0, mem_ready and mem_error=1 on beat 3, identical timing.
- During WAIT, send prog_we with prog_addr=0x40. Required: the write is ignored and the burst returns the old value. In IDLE, the same write with a simultaneous request returns the new value on beat 0.
- Assert reset_n=0 on beat 2. Required: mem_data_valid, mem_ready and prog_busy go 0 at once. After release, the held request gives a complete new burst from beat 0.
